// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS core: sequences ALU, register file, IR/PC
// and unified memory per instruction, with a bounded wait on the memory ready handshake.
module mips_multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic       illegal_instr,
  output logic       mem_timeout
);

  // state    | meaning
  // S_RST    | held in / just out of reset, all outputs low
  // S_FETCH  | read instruction at PC, PC <= PC+4 on ready
  // S_DECODE | read registers, precompute branch target
  // S_MEMADR | compute load/store address
  // S_MEMRD  | load data read, wait for ready
  // S_MEMWB  | write loaded data to rt
  // S_MEMWR  | store data write, wait for ready
  // S_EXEC   | R-type ALU operation
  // S_ALUWB  | write ALU result to rd
  // S_BRANCH | compare for beq/bne, load target if taken
  // S_ADDIEX | rs + sign-extended immediate
  // S_ADDIWB | write addi result to rt
  // S_JUMP   | load jump target
  // S_JR     | load rs into PC
  typedef enum logic [3:0] {
    S_RST, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC, S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP, S_JR
  } state_t;

  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       mem_write;
    logic       fetch;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       pc_uncond;
    logic       branch;
    logic       mem_wait;
    logic       decode;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;

  localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  function automatic ctrl_t ctrl_of(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_req   = 1'b1;
        c.alu_src_b = 2'b01;
        c.fetch     = 1'b1;
        c.mem_wait  = 1'b1;
      end
      S_DECODE: begin
        c.alu_src_b = 2'b11;
        c.decode    = 1'b1;
      end
      S_MEMADR, S_ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        c.mem_req  = 1'b1;
        c.iord     = 1'b1;
        c.mem_wait = 1'b1;
      end
      S_MEMWB: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        c.mem_req   = 1'b1;
        c.iord      = 1'b1;
        c.mem_write = 1'b1;
        c.mem_wait  = 1'b1;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      S_ALUWB: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      S_ADDIWB: c.reg_write = 1'b1;
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b01;
        c.pc_src    = 2'b01;
        c.branch    = 1'b1;
      end
      S_JUMP: begin
        c.pc_src    = 2'b10;
        c.pc_uncond = 1'b1;
      end
      S_JR: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
        c.pc_uncond = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t        state, state_nxt, decode_tgt;
  ctrl_t         ctrl_q;
  logic [CW-1:0] wait_cnt;
  logic          decode_ok;
  logic          timeout_hit;

  always_comb begin
    decode_tgt = S_FETCH;
    decode_ok  = 1'b1;
    case (opcode)
      OP_LW, OP_SW:    decode_tgt = S_MEMADR;
      OP_BEQ, OP_BNE:  decode_tgt = S_BRANCH;
      OP_ADDI:         decode_tgt = S_ADDIEX;
      OP_J:            decode_tgt = S_JUMP;
      OP_RTYPE: begin
        if (funct == FN_JR) begin
          decode_tgt = S_JR;
        end else if (funct inside {FN_SLL, FN_SRL, FN_ADD, FN_SUB, FN_AND, FN_OR}) begin
          decode_tgt = S_EXEC;
        end else begin
          decode_ok = 1'b0;
        end
      end
      default: decode_ok = 1'b0;
    endcase
  end

  // A ready arriving in the last allowed cycle completes normally instead of aborting.
  assign timeout_hit = ctrl_q.mem_wait && (MEM_TIMEOUT > 0) && !mem_ready
                       && (wait_cnt == CNT_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      S_RST:    state_nxt = S_FETCH;
      S_FETCH:  state_nxt = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: state_nxt = decode_tgt;
      S_MEMADR: state_nxt = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (mem_ready)        state_nxt = S_MEMWB;
        else if (timeout_hit) state_nxt = S_FETCH;
      end
      S_MEMWR: begin
        if (mem_ready || timeout_hit) state_nxt = S_FETCH;
      end
      S_EXEC:   state_nxt = S_ALUWB;
      S_ADDIEX: state_nxt = S_ADDIWB;
      default:  state_nxt = S_FETCH;
    endcase
  end

  // Static decode is registered from the next state; only ready/zero gating stays combinational.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_RST;
      ctrl_q   <= '0;
      wait_cnt <= '0;
    end else begin
      state  <= state_nxt;
      ctrl_q <= ctrl_of(state_nxt);
      if (state_nxt != state || timeout_hit) begin
        wait_cnt <= '0;
      end else if (!mem_ready) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  assign mem_req       = ctrl_q.mem_req;
  assign IorD          = ctrl_q.iord;
  assign MemWrite      = ctrl_q.mem_write;
  assign IRWrite       = ctrl_q.fetch & mem_ready;
  assign RegDst        = ctrl_q.reg_dst;
  assign MemtoReg      = ctrl_q.mem_to_reg;
  assign RegWrite      = ctrl_q.reg_write;
  assign ALUSrcA       = ctrl_q.alu_src_a;
  assign ALUSrcB       = ctrl_q.alu_src_b;
  assign ALUOp         = ctrl_q.alu_op;
  assign PCSrc         = ctrl_q.pc_src;
  // opcode[0] separates bne (taken on ~zero) from beq (taken on zero).
  assign PCEn          = (ctrl_q.fetch & mem_ready) | ctrl_q.pc_uncond
                         | (ctrl_q.branch & (opcode[0] ? ~zero : zero));
  assign illegal_instr = ctrl_q.decode & ~decode_ok;
  assign mem_timeout   = timeout_hit;

endmodule
